// File: rtl/alu_rs.sv
// ALU reservation station: compacting queue between ID and EX.
// Snoops ROB broadcasts and dispatches the oldest ready op to EX.
//
// Ports:
//   clk, rst (async, active-low), flush (sync clear)
//   issue_*  : op from ID; issue_ready back-pressure
//   bc_*     : ROB result broadcast (tag/value)
//   ex_*     : dispatched op to EX, valid/ready handshake
//   free_count : number of empty entries
module alu_rs #(
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 6,
  localparam int CNT_W   = $clog2(RS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              issue_s1_rdy,
  input  logic              issue_s2_rdy,
  input  logic [DATA_W-1:0] issue_s1_val,
  input  logic [DATA_W-1:0] issue_s2_val,
  input  logic [TAG_W-1:0]  issue_s1_tag,
  input  logic [TAG_W-1:0]  issue_s2_tag,
  input  logic              bc_valid,
  input  logic [TAG_W-1:0]  bc_tag,
  input  logic [DATA_W-1:0] bc_value,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [TAG_W-1:0]  ex_tag,
  output logic [DATA_W-1:0] ex_s1,
  output logic [DATA_W-1:0] ex_s2,
  output logic [CNT_W-1:0]  free_count
);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
    logic              s1_rdy;
    logic [DATA_W-1:0] s1_val;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_rdy;
    logic [DATA_W-1:0] s2_val;
    logic [TAG_W-1:0]  s2_tag;
  } ent_t;

  ent_t             ent_q [RS_DEPTH];
  ent_t             ent_d [RS_DEPTH];
  ent_t             src;
  ent_t             nw;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] sel;
  logic [CNT_W-1:0] wr_idx;
  logic             found;
  logic             fire;
  logic             accept;

  assign issue_ready = count_q < CNT_W'(RS_DEPTH);
  assign free_count  = CNT_W'(RS_DEPTH) - count_q;
  assign accept      = issue_valid && issue_ready;
  assign ex_valid    = found && !flush;
  assign fire        = ex_valid && ex_ready;

  // Oldest entry with both operands ready wins; re-evaluated
  // every cycle so an older entry can overtake a stalled one.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    ex_op  = '0;
    ex_tag = '0;
    ex_s1  = '0;
    ex_s2  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!found && ent_q[i].valid &&
          ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        found  = 1'b1;
        sel    = CNT_W'(i);
        ex_op  = ent_q[i].op;
        ex_tag = ent_q[i].tag;
        ex_s1  = ent_q[i].s1_val;
        ex_s2  = ent_q[i].s2_val;
      end
    end
  end

  // Incoming entry, with same-cycle broadcast forwarding.
  always_comb begin
    nw        = '0;
    nw.valid  = 1'b1;
    nw.op     = issue_op;
    nw.tag    = issue_tag;
    nw.s1_rdy = issue_s1_rdy;
    nw.s1_val = issue_s1_val;
    nw.s1_tag = issue_s1_tag;
    nw.s2_rdy = issue_s2_rdy;
    nw.s2_val = issue_s2_val;
    nw.s2_tag = issue_s2_tag;
    if (bc_valid && !issue_s1_rdy && issue_s1_tag == bc_tag) begin
      nw.s1_rdy = 1'b1;
      nw.s1_val = bc_value;
    end
    if (bc_valid && !issue_s2_rdy && issue_s2_tag == bc_tag) begin
      nw.s2_rdy = 1'b1;
      nw.s2_val = bc_value;
    end
  end

  // Next state ordering: shift out dispatched entry, snoop the
  // shifted queue, then append the new op at the new tail.
  always_comb begin
    src    = '0;
    wr_idx = count_q - CNT_W'(fire);
    for (int i = 0; i < RS_DEPTH; i++) begin
      src = ent_q[i];
      if (fire && CNT_W'(i) >= sel) begin
        if (i < RS_DEPTH - 1) src = ent_q[(i + 1) % RS_DEPTH];
        else                  src = '0;
      end
      if (bc_valid && src.valid) begin
        if (!src.s1_rdy && src.s1_tag == bc_tag) begin
          src.s1_rdy = 1'b1;
          src.s1_val = bc_value;
        end
        if (!src.s2_rdy && src.s2_tag == bc_tag) begin
          src.s2_rdy = 1'b1;
          src.s2_val = bc_value;
        end
      end
      if (accept && CNT_W'(i) == wr_idx) src = nw;
      if (flush) src.valid = 1'b0;
      ent_d[i] = src;
    end
    count_d = count_q + CNT_W'(accept) - CNT_W'(fire);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule
